// File: rtl/i2c_fifo_read_prefetch.sv
// First-word-fall-through prefetch stage on the I2C async FIFO read side.
// Optional level_o port enabled by defining I2C_FIFO_PREFETCH_LEVEL_EN.
module i2c_fifo_read_prefetch #(
    parameter int data_size = 8
) (
    input  logic                 read_clock_i,
    input  logic                 read_reset_n_i,
    input  logic                 flush_i,
    input  logic                 read_empty_i,
    input  logic [data_size-1:0] read_data_i,
    output logic                 read_inc_o,
    output logic [data_size-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i
`ifdef I2C_FIFO_PREFETCH_LEVEL_EN
    ,
    output logic [1:0]           level_o
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 inflight_q, inflight_d;
    logic                 head_q, head_d;
    logic                 tail_q, tail_d;
    logic [data_size-1:0] mem_q [2];
    logic [data_size-1:0] mem_d [2];

    logic                 deq;
    logic                 capture;
    logic [2:0]           occ;

    always_ff @(posedge read_clock_i or negedge read_reset_n_i) begin
        if (!read_reset_n_i) begin
            state_q    <= EMPTY;
            inflight_q <= 1'b0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            mem_q[0]   <= mem_d[0];
            mem_q[1]   <= mem_d[1];
        end
    end

    // Outputs: head word and valid come straight from flops.
    always_comb begin
        valid_o    = (state_q != EMPTY);
        data_o     = mem_q[head_q];
        deq        = valid_o & ready_i;
        occ        = {1'b0, state_q} + {2'b00, inflight_q};
        read_inc_o = ~read_empty_i & ~flush_i
                   & (occ < (3'd2 + {2'b00, deq}));
    end

    always_comb begin
        capture    = inflight_q & ~flush_i;
        state_d    = state_q;
        inflight_d = read_inc_o & ~read_empty_i & ~flush_i;
        head_d     = head_q ^ deq;
        tail_d     = tail_q ^ capture;
        mem_d[0]   = mem_q[0];
        mem_d[1]   = mem_q[1];
        if (capture) begin
            mem_d[tail_q] = read_data_i;
        end
        unique case (state_q)
            EMPTY: if (capture) state_d = ONE;
            ONE: begin
                if (capture && !deq) state_d = TWO;
                else if (!capture && deq) state_d = EMPTY;
            end
            TWO: if (deq) state_d = ONE;
            default: state_d = EMPTY;
        endcase
        // A flush drops everything, including the word arriving this cycle.
        if (flush_i) begin
            state_d = EMPTY;
            head_d  = 1'b0;
            tail_d  = 1'b0;
        end
    end

`ifdef I2C_FIFO_PREFETCH_LEVEL_EN
    assign level_o = state_q;
`endif

endmodule

// File: tb/tb_i2c_fifo_read_prefetch.sv
// Randomized bench for i2c_fifo_read_prefetch against a queue-based model.
// Models the FIFO memory and empty flag; checks handshake, order and pops.
module tb_i2c_fifo_read_prefetch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush_i;
    logic       empty_i;
    logic [7:0] rdata_i;
    logic       inc_o;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
`ifdef I2C_FIFO_PREFETCH_LEVEL_EN
    logic [1:0] level_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] fifo [$];
    logic [7:0] mq [$];
    bit         mi;

    always #5 clk = ~clk;

    i2c_fifo_read_prefetch #(.data_size(8)) dut (
        .read_clock_i   (clk),
        .read_reset_n_i (rst_n),
        .flush_i        (flush_i),
        .read_empty_i   (empty_i),
        .read_data_i    (rdata_i),
        .read_inc_o     (inc_o),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i)
`ifdef I2C_FIFO_PREFETCH_LEVEL_EN
        ,
        .level_o        (level_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // One cycle, entered and left at a falling edge.
    task automatic cyc(input bit rdy, input bit fl);
        bit         exp_v, deq, exp_inc, popped;
        logic [7:0] w;
        int         pend;
        ready_i = rdy;
        flush_i = fl;
        empty_i = (fifo.size() == 0);
        #1;
        exp_v = (mq.size() != 0);
        deq   = exp_v && rdy;
        pend  = mq.size() + int'(mi) - int'(deq);
        exp_inc = !empty_i && !fl && (pend < 2);
        chk("valid", 32'(valid_o), 32'(exp_v));
        if (exp_v) chk("data", 32'(data_o), 32'(mq[0]));
        chk("read_inc", 32'(inc_o), 32'(exp_inc));
`ifdef I2C_FIFO_PREFETCH_LEVEL_EN
        chk("level", 32'(level_o), 32'(mq.size()));
`endif
        popped = inc_o && (fifo.size() != 0);
        w = popped ? fifo.pop_front() : 8'h00;
        @(posedge clk);
        if (fl) begin
            mq.delete();
            mi = 1'b0;
        end else begin
            if (deq) void'(mq.pop_front());
            if (mi) mq.push_back(rdata_i);
            mi = exp_inc;
        end
        #1;
        rdata_i = popped ? w : 8'($urandom);
        @(negedge clk);
    endtask

    task automatic push_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) fifo.push_back(first + 8'(i));
    endtask

    initial begin
        rst_n   = 1'b1;
        flush_i = 1'b0;
        empty_i = 1'b1;
        rdata_i = 8'h00;
        ready_i = 1'b0;
        mi      = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_inc", 32'(inc_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // single word
        fifo.push_back(8'hA5);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);

        // backpressure then drain
        push_seq(8'h01, 5);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0);

        // streaming
        push_seq(8'h10, 8);
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0);

        // flush with one stored and one in flight
        push_seq(8'h30, 3);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);

        // alternating ready
        push_seq(8'h40, 6);
        for (int i = 0; i < 16; i++) cyc(1'(i % 2 == 0), 1'b0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) fifo.push_back(8'($urandom));
            cyc(1'($urandom_range(0, 3) != 0), $urandom_range(0, 24) == 0);
        end

        // reset mid-stream with two words buffered
        push_seq(8'h60, 4);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);
        fifo.delete();
        empty_i = 1'b1;
        rst_n   = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(valid_o), 32'd0);
        chk("mid_rst_data", 32'(data_o), 32'd0);
        chk("mid_rst_inc", 32'(inc_o), 32'd0);
`ifdef I2C_FIFO_PREFETCH_LEVEL_EN
        chk("mid_rst_level", 32'(level_o), 32'd0);
`endif
        mq.delete();
        mi = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        push_seq(8'h70, 3);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
